// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision frame Viterbi decoder for rate 1/2 or 1/3 codes
// Optional build macro VITERBI_ERASURE_EN adds i_sym_erase to drop marked bits from the branch metric.
module viterbi_decoder #(
    parameter int K         = 7,
    parameter int FRAME_LEN = 128,
    parameter int MW        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3*K-1:0]   i_gen_poly,
    input  logic             i_code_rate,
    input  logic [2:0]       i_sym,
`ifdef VITERBI_ERASURE_EN
    input  logic [2:0]       i_sym_erase,
`endif
    input  logic             i_sym_valid,
    output logic             o_sym_ready,
    output logic             o_dec_bit,
    output logic             o_dec_valid,
    output logic             o_dec_last,
    input  logic             i_dec_ready,
    output logic             o_busy
);

    localparam int SW = K - 1;
    localparam int NS = 1 << SW;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [MW-1:0] PM_INIT  = MW'(1 << (MW - 2));
    localparam logic [MW-1:0] PM_HALF  = MW'(1 << (MW - 1));
    localparam logic [MW-1:0] PM_MAX   = {MW{1'b1}};
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACS, S_TB, S_OUT} state_t;

    state_t               state;
    state_t               state_nx;
    logic [MW-1:0]        pm       [NS];
    logic [MW-1:0]        pm_raw   [NS];
    logic [MW-1:0]        pm_new   [NS];
    logic [MW-1:0]        raw_min;
    logic [NS-1:0]        surv_vec;
    logic [NS-1:0]        surv_mem [FRAME_LEN];
    logic [FRAME_LEN-1:0] dec_bits;
    logic [CW-1:0]        step;
    logic [CW-1:0]        out_idx;
    logic                 tb_first;
    logic [SW-1:0]        tb_state;
    logic [SW-1:0]        best_state;
    logic [3*K-1:0]       poly_q;
    logic                 rate_q;
    logic [3*K-1:0]       poly_use;
    logic                 rate_use;
    logic [2:0]           erase_use;
    logic                 sym_ready;
    logic                 sym_hs;
    logic                 last_step;
    logic                 out_hs;
    logic                 out_last;

`ifdef VITERBI_ERASURE_EN
    assign erase_use = i_sym_erase;
`else
    assign erase_use = 3'b000;
`endif

    // Step 0 runs in IDLE before the frame configuration has been registered.
    assign poly_use  = (state == S_IDLE) ? i_gen_poly  : poly_q;
    assign rate_use  = (state == S_IDLE) ? i_code_rate : rate_q;
    assign sym_ready = !rst && (state == S_IDLE || state == S_ACS);
    assign sym_hs    = i_sym_valid && sym_ready;
    assign last_step = (step == LAST_IDX);
    assign out_last  = (out_idx == LAST_IDX);
    assign out_hs    = o_dec_valid && i_dec_ready;

    function automatic logic [1:0] branch_metric(
        input logic [K-1:0]   r,
        input logic [3*K-1:0] poly,
        input logic           rate,
        input logic [2:0]     sym,
        input logic [2:0]     erase
    );
        logic [1:0] bm;
        bm = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if ((i < 2 || rate) && !erase[i] && ((^(r & poly[i*K +: K])) != sym[i]))
                bm = bm + 2'd1;
        end
        return bm;
    endfunction

    function automatic logic [MW-1:0] pm_reset_value(input int s);
        return (s == 0) ? '0 : PM_INIT;
    endfunction

    always_comb begin : acs
        logic [SW-1:0] ns_v;
        logic [SW-1:0] p0;
        logic [SW-1:0] p1;
        logic [MW:0]   sum0;
        logic [MW:0]   sum1;
        logic [MW-1:0] c0;
        logic [MW-1:0] c1;
        ns_v     = '0;
        p0       = '0;
        p1       = '0;
        sum0     = '0;
        sum1     = '0;
        c0       = '0;
        c1       = '0;
        raw_min  = PM_MAX;
        surv_vec = '0;
        for (int s = 0; s < NS; s++) begin
            ns_v = SW'(s);
            p0   = {1'b0, ns_v[SW-1:1]};
            p1   = {1'b1, ns_v[SW-1:1]};
            sum0 = {1'b0, pm[p0]} + {{(MW-1){1'b0}},
                   branch_metric({p0, ns_v[0]}, poly_use, rate_use, i_sym, erase_use)};
            sum1 = {1'b0, pm[p1]} + {{(MW-1){1'b0}},
                   branch_metric({p1, ns_v[0]}, poly_use, rate_use, i_sym, erase_use)};
            c0   = sum0[MW] ? PM_MAX : sum0[MW-1:0];
            c1   = sum1[MW] ? PM_MAX : sum1[MW-1:0];
            if (c1 < c0) begin
                pm_raw[s]   = c1;
                surv_vec[s] = 1'b1;
            end else begin
                pm_raw[s]   = c0;
            end
            if (pm_raw[s] < raw_min)
                raw_min = pm_raw[s];
        end
        for (int s = 0; s < NS; s++)
            pm_new[s] = (raw_min >= PM_HALF) ? pm_raw[s] - PM_HALF : pm_raw[s];
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin : best_sel
        logic [MW-1:0] best_pm;
        best_pm    = pm[0];
        best_state = '0;
        for (int s = 1; s < NS; s++) begin
            if (pm[s] < best_pm) begin
                best_pm    = pm[s];
                best_state = SW'(s);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        o_sym_ready = sym_ready;
        o_busy      = !rst && (state != S_IDLE);
        o_dec_valid = !rst && (state == S_OUT);
        o_dec_bit   = 1'b0;
        o_dec_last  = 1'b0;
        if (o_dec_valid) begin
            o_dec_bit  = dec_bits[out_idx];
            o_dec_last = out_last;
        end
        case (state)
            S_IDLE:  if (sym_hs) state_nx = last_step ? S_TB : S_ACS;
            S_ACS:   if (sym_hs && last_step) state_nx = S_TB;
            S_TB:    if (!tb_first && step == '0) state_nx = S_OUT;
            S_OUT:   if (out_hs && out_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step     <= '0;
            out_idx  <= '0;
            tb_first <= 1'b0;
            tb_state <= '0;
            poly_q   <= '0;
            rate_q   <= 1'b0;
            dec_bits <= '0;
            for (int s = 0; s < NS; s++)
                pm[s] <= pm_reset_value(s);
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_ACS: begin
                    if (sym_hs) begin
                        for (int s = 0; s < NS; s++)
                            pm[s] <= pm_new[s];
                        if (state == S_IDLE) begin
                            poly_q <= i_gen_poly;
                            rate_q <= i_code_rate;
                        end
                        // The step counter parks on the last index and counts down through traceback.
                        if (last_step)
                            tb_first <= 1'b1;
                        else
                            step <= step + CW'(1);
                    end
                end
                S_TB: begin
                    if (tb_first) begin
                        tb_first <= 1'b0;
                        tb_state <= best_state;
                    end else begin
                        dec_bits[step] <= tb_state[0];
                        tb_state       <= {surv_mem[step][tb_state], tb_state[SW-1:1]};
                        if (step != '0)
                            step <= step - CW'(1);
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (out_last) begin
                            out_idx <= '0;
                            for (int s = 0; s < NS; s++)
                                pm[s] <= pm_reset_value(s);
                        end else begin
                            out_idx <= out_idx + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Survivor store has no reset: every row is rewritten before traceback reads it.
    always_ff @(posedge clk) begin
        if (sym_hs)
            surv_mem[step] <= surv_vec;
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - self-checking bench for viterbi_decoder
// Reference encoder plus known information bits form the expected decoded stream.
module tb_viterbi_decoder;
    localparam int K  = 7;
    localparam int FL = 128;
    localparam int MW = 8;
    localparam logic [20:0] POLY = {7'o165, 7'o133, 7'o171};

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] i_gen_poly;
    logic        i_code_rate;
    logic [2:0]  i_sym;
    logic        i_sym_valid;
    logic        o_sym_ready;
    logic        o_dec_bit;
    logic        o_dec_valid;
    logic        o_dec_last;
    logic        i_dec_ready;
    logic        o_busy;
`ifdef VITERBI_ERASURE_EN
    logic [2:0]  i_sym_erase;
`endif

    always #5 clk = ~clk;

    viterbi_decoder #(.K(K), .FRAME_LEN(FL), .MW(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_gen_poly  (i_gen_poly),
        .i_code_rate (i_code_rate),
        .i_sym       (i_sym),
`ifdef VITERBI_ERASURE_EN
        .i_sym_erase (i_sym_erase),
`endif
        .i_sym_valid (i_sym_valid),
        .o_sym_ready (o_sym_ready),
        .o_dec_bit   (o_dec_bit),
        .o_dec_valid (o_dec_valid),
        .o_dec_last  (o_dec_last),
        .i_dec_ready (i_dec_ready),
        .o_busy      (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       data_bits [FL];
    logic [2:0] syms      [FL];
    logic [2:0] erase_arr [FL];
    logic       exp_q     [$];
    bit         sink_rnd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    initial begin
        i_dec_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_dec_ready = sink_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output checker: every accepted bit against the expected queue, plus stall stability.
    int   frame_pos       = 0;
    int   first_valid_cyc = 0;
    logic prev_valid      = 1'b0;
    logic prev_stall      = 1'b0;
    logic prev_bit        = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_stall <= 1'b0;
            frame_pos  <= 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", o_dec_valid, 1);
                check("stall_bit_held", o_dec_bit, prev_bit);
            end
            if (o_dec_valid && !prev_valid)
                first_valid_cyc <= cyc;
            if (o_dec_valid && i_dec_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_output_bit");
                end else begin
                    check($sformatf("dec_bit[%0d]", frame_pos), o_dec_bit, exp_q.pop_front());
                    check($sformatf("dec_last[%0d]", frame_pos), o_dec_last, (frame_pos == FL - 1));
                end
                frame_pos <= (frame_pos == FL - 1) ? 0 : frame_pos + 1;
            end
            prev_valid <= o_dec_valid;
            prev_stall <= o_dec_valid && !i_dec_ready;
            prev_bit   <= o_dec_bit;
        end
    end

    task automatic set_zero();
        for (int t = 0; t < FL; t++) data_bits[t] = 1'b0;
    endtask

    task automatic set_impulse();
        for (int t = 0; t < FL; t++) data_bits[t] = (t == 0);
    endtask

    // PRBS-7, x^7 + x^6 + 1, seeded with all ones.
    task automatic set_prbs();
        logic [6:0] s;
        logic       nb;
        s = 7'h7F;
        for (int t = 0; t < FL; t++) begin
            nb = s[6] ^ s[5];
            s  = {s[5:0], nb};
            data_bits[t] = nb;
        end
    endtask

    task automatic encode(input logic [20:0] poly, input bit r3);
        logic [6:0] sr;
        sr = '0;
        for (int t = 0; t < FL; t++) begin
            sr = {sr[5:0], data_bits[t]};
            syms[t][0] = ^(sr & poly[6:0]);
            syms[t][1] = ^(sr & poly[13:7]);
            // At rate 1/2 bit 2 carries junk that the decoder must ignore.
            syms[t][2] = r3 ? ^(sr & poly[20:14]) : data_bits[t];
            erase_arr[t] = 3'b000;
        end
    endtask

    task automatic feed(input bit rnd, input bit garble, input int abort_at, output int first_hs);
        int idx;
        int guard;
        bit garbled;
        idx      = 0;
        guard    = 0;
        garbled  = 1'b0;
        first_hs = -1;
        while (idx < FL && idx != abort_at) begin
            if (guard >= 8 * FL) begin
                fail("feed_timeout");
                break;
            end
            i_sym_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_sym       = syms[idx];
`ifdef VITERBI_ERASURE_EN
            i_sym_erase = erase_arr[idx];
`endif
            @(negedge clk);
            if (i_sym_valid && o_sym_ready) begin
                if (idx == 0) first_hs = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
            if (garble && idx >= 1 && !garbled) begin
                i_gen_poly  = ~i_gen_poly;
                i_code_rate = ~i_code_rate;
                garbled     = 1'b1;
            end
            guard++;
        end
        i_sym_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20 * FL) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            fail({nm, "_drain_timeout"});
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check({nm, "_idle_ready"}, o_sym_ready, 1);
        check({nm, "_idle_busy"}, o_busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string nm, input logic [20:0] poly, input bit r3,
                             input bit rnd, input bit garble, input bit chk_lat);
        int fh;
        for (int t = 0; t < FL; t++) exp_q.push_back(data_bits[t]);
        sink_rnd    = rnd;
        i_gen_poly  = poly;
        i_code_rate = r3;
        feed(rnd, garble, -1, fh);
        i_sym_valid = 1'b1;
        @(negedge clk);
        check({nm, "_ready_low_after_frame"}, o_sym_ready, 0);
        check({nm, "_busy_after_frame"}, o_busy, 1);
        @(posedge clk);
        #1;
        i_sym_valid = 1'b0;
        drain(nm);
        if (chk_lat)
            check({nm, "_first_valid_latency"}, first_valid_cyc - fh, FL + FL + 1);
        sink_rnd = 1'b0;
    endtask

    initial begin
        int         ones;
        int         fh;
        logic [2:0] imp_lit [7];
        imp_lit = '{3'd3, 3'd2, 3'd0, 3'd3, 3'd3, 3'd1, 3'd3};

        rst         = 1'b1;
        i_sym_valid = 1'b0;
        i_sym       = 3'b000;
        i_gen_poly  = POLY;
        i_code_rate = 1'b0;
`ifdef VITERBI_ERASURE_EN
        i_sym_erase = 3'b000;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sym_ready", o_sym_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_dec_valid", o_dec_valid, 0);
        check("rst_dec_bit", o_dec_bit, 0);
        check("rst_dec_last", o_dec_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_sym_ready", o_sym_ready, 1);
        check("idle_busy", o_busy, 0);
        @(posedge clk);
        #1;

        // Hand-derived anchors for the reference model.
        set_prbs();
        ones = 0;
        for (int t = 0; t < 127; t++) ones += int'(data_bits[t]);
        check("model_prbs7_ones", ones, 64);
        set_impulse();
        encode(POLY, 1'b0);
        for (int j = 0; j < 7; j++)
            check($sformatf("model_impulse_sym[%0d]", j), {1'b0, syms[j][1:0]}, imp_lit[j]);
        encode(POLY, 1'b1);
        check("model_r3_impulse_sym0", syms[0], 3'd7);

        set_zero();
        encode(POLY, 1'b0);
        run_frame("all_zero", POLY, 1'b0, 1'b0, 1'b0, 1'b0);

        set_prbs();
        encode(POLY, 1'b0);
        run_frame("prbs", POLY, 1'b0, 1'b0, 1'b0, 1'b1);

        set_impulse();
        encode(POLY, 1'b0);
        run_frame("impulse", POLY, 1'b0, 1'b0, 1'b0, 1'b0);

        set_prbs();
        encode(POLY, 1'b1);
        syms[10][0] = ~syms[10][0];
        syms[50][1] = ~syms[50][1];
        syms[90][2] = ~syms[90][2];
        run_frame("r3_flips", POLY, 1'b1, 1'b0, 1'b1, 1'b0);

        set_prbs();
        encode(POLY, 1'b0);
        run_frame("random_stall", POLY, 1'b0, 1'b1, 1'b1, 1'b0);

        set_prbs();
        encode(POLY, 1'b0);
        i_gen_poly  = POLY;
        i_code_rate = 1'b0;
        feed(1'b0, 1'b0, 60, fh);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", o_sym_ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", o_busy, 0);
        check("abort_ready", o_sym_ready, 1);
        @(posedge clk);
        #1;
        set_zero();
        encode(POLY, 1'b0);
        run_frame("after_abort", POLY, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef VITERBI_ERASURE_EN
        set_prbs();
        encode(POLY, 1'b0);
        for (int t = 0; t < FL; t++) begin
            for (int i = 0; i < 2; i++) begin
                if ((2 * t + i) % 4 == 3) begin
                    erase_arr[t][i] = 1'b1;
                    syms[t][i]      = ~syms[t][i];
                end
            end
        end
        run_frame("erasure", POLY, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision, frame-based Viterbi decoder; the receive-side counterpart of conv_encoder.
- Accepts code symbols at rate 1/2 or 1/3 through a valid/ready stream and runs one add-compare-select (ACS) step per symbol over all 2^(K-1) states.
- Stores survivor bits, traces back from the best final state, then streams the FRAME_LEN decoded bits out in original order.

Parameters:
- K, 7: constraint length; state count NS = 2^(K-1).
- FRAME_LEN, 128: information bits (trellis steps) per frame.
- MW, 8: path-metric width, unsigned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_gen_poly  in  3*K  polynomial i at [i*K +: K]; bit k taps register position k (bit 0 = newest input)
- i_code_rate  in  1  0 = rate 1/2 (polys 0,1), 1 = rate 1/3 (polys 0,1,2)
- i_sym  in  3  received hard bits; bit i corresponds to poly i; bit 2 ignored at rate 1/2
- i_sym_valid  in  1  symbol present
- o_sym_ready  out  1  decoder can accept a symbol
- o_dec_bit  out  1  decoded information bit
- o_dec_valid  out  1  o_dec_bit valid
- o_dec_last  out  1  marks the FRAME_LEN-th output bit
- i_dec_ready  in  1  downstream accepts the output bit
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: o_sym_ready=0, o_dec_valid=0, o_dec_bit=0, o_dec_last=0, o_busy=0. FSM goes to IDLE, step counter 0, metrics initialised (below). Reset mid-frame discards all frame data.
- FSM: IDLE -> ACS -> TRACEBACK -> OUTPUT -> IDLE.
- IDLE:
  - o_sym_ready=1.
  - PM[0]=0, PM[s≠0]=2^(MW-2).
  - On the first handshake (i_sym_valid & o_sym_ready), latch i_gen_poly and i_code_rate for the whole frame, perform ACS step 0, go to ACS.
  - Mid-frame changes on i_gen_poly / i_code_rate are ignored.
- Trellis convention (matches encoder):
  - From state p with input b, the register is {p,b}.
  - Next state ns = {p[K-3:0], b}.
  - Expected bit i = XOR over k of ({p,b}[k] & poly_i[k]).
  - The predecessors of ns are p_x = {x, ns[K-2:1]} for x ∈ {0,1}, with b = ns[0].
- ACS step:
  - BM = Hamming distance between the expected and received bits over the active rate (0..2 or 0..3).
  - Candidate_x = PM[p_x] + BM_x.
  - Pick the smaller candidate; ties select x=0. Store survivor bit x in SURV[step][ns].
  - All NS metrics update together at the clock edge following the handshake.
- ACS state:
  - o_sym_ready=1; one step per handshake; idle cycles hold all state.
  - Normalisation: if the minimum new PM ≥ 2^(MW-1), subtract 2^(MW-1) from every new PM in the same cycle.
  - Metric adds saturate at 2^MW-1.
  - After step FRAME_LEN-1, o_sym_ready drops on the next cycle; go to TRACEBACK.
- TRACEBACK:
  - First cycle: select best state = lowest PM, ties to lowest index.
  - Then one step per cycle for t = FRAME_LEN-1 down to 0: DEC[t] = s[0]; s <= {SURV[t][s], s[K-2:1]}.
  - Takes exactly FRAME_LEN+1 cycles, then go to OUTPUT.
- OUTPUT:
  - o_dec_valid=1, o_dec_bit = DEC[n] for n = 0..FRAME_LEN-1.
  - Advance only on o_dec_valid & i_dec_ready; o_dec_bit is held stable while stalled.
  - o_dec_last=1 with n = FRAME_LEN-1.
  - After the last handshake: o_dec_valid=0, metrics re-initialised, return to IDLE. IDLE is ready on the following cycle.
- Storage: SURV is FRAME_LEN x NS bits; DEC is FRAME_LEN bits. Both may map to registers or RAM with at most 1-cycle read latency, absorbed inside the stated cycle counts.
- Symbols offered outside IDLE/ACS are not accepted (o_sym_ready=0).

Optional Feature:
- Macro: VITERBI_ERASURE_EN.
- Defined:
  - Adds input port i_sym_erase [2:0], sampled with i_sym.
  - An erased bit contributes 0 to BM regardless of the expected value (depunctured or unreliable positions).
- Undefined: the port is absent and all active bits always count.

Test Plan:
- Setup for every scenario: K=7, polys 171/133 octal, rate 1/2, FRAME_LEN=128.
- All-zero symbols -> 128 output bits all 0, o_dec_last on bit 127, final best state 0.
- Encode a PRBS-7 frame with a reference encoder and feed error-free -> output equals the PRBS bits exactly; no stalls give the latency 128 ACS + 129 TB cycles before the first o_dec_valid.
- Same frame at rate 1/3 (third poly 165 octal) with single bit flips at steps 10, 50 and 90 -> output equals the original PRBS.
- Toggle i_sym_valid and i_dec_ready randomly at 50% -> same output; o_dec_bit stable during stalls; no symbol dropped or duplicated.
- Assert rst at ACS step 60 then start a fresh all-zero frame -> clean all-zero output, with no residue of the aborted frame.
- With VITERBI_ERASURE_EN: erase every 4th bit of an error-free PRBS frame -> output equals the PRBS.
